// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, bubble encoding and fetch FSM states.
// Imported by the fetch-stage RTL.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } if_state_e;

    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
        return a & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load, flush and hold.
// Flush inserts a bubble but keeps the recorded PC.
module ifid_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            hold,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic            valid
);

    // Register update: reset, then bubble, then capture unless held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load && !hold) begin
            pc    <= pc_d;
            instr <= instr_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: PC register, BOOT/RUN/HALT fetch FSM and IF/ID register.
// Define IF_MISALIGN_TRAP_EN to halt with fault_o on misaligned redirects.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_data_i,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_instr_o,
    output logic            ifid_valid_o,
    output logic            fault_o
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            load, flush, hold;
    logic            fault_set;

    assign imem_addr_o = pc_q;

    // Next state, next PC and IF/ID controls; redirect beats stall.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        load      = 1'b0;
        flush     = 1'b0;
        hold      = 1'b0;
        fault_set = 1'b0;
        unique case (state_q)
            BOOT, RUN: begin
                if (redirect_i) begin
                    flush   = 1'b1;
                    state_d = RUN;
`ifdef IF_MISALIGN_TRAP_EN
                    if (redirect_pc_i[1:0] != 2'b00) begin
                        state_d   = HALT;
                        fault_set = 1'b1;
                    end else begin
                        pc_d = redirect_pc_i;
                    end
`else
                    pc_d = align4(redirect_pc_i);
`endif
                end else if (state_q == BOOT) begin
                    state_d = RUN;
                end else if (stall_i) begin
                    hold = 1'b1;
                end else begin
                    load = 1'b1;
                    pc_d = pc_q + XLEN'(4);
                end
            end
            HALT: begin
                flush = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    logic fault_q;

    // Sticky misaligned-fetch fault, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end
    end

    assign fault_o = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_set;
    assign fault_o      = 1'b0;
`endif

    ifid_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .flush  (flush),
        .hold   (hold),
        .pc_d   (pc_q),
        .instr_d(imem_data_i),
        .pc     (ifid_pc_o),
        .instr  (ifid_instr_o),
        .valid  (ifid_valid_o)
    );

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter: NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: stall_i  input  1  hazard-unit hold request.
REQ-006 SHALL have port: redirect_i  input  1  branch/jump taken in EX; load redirect_pc_i.
REQ-007 SHALL have port: redirect_pc_i  input  32  redirect target byte address.
REQ-008 SHALL have port: imem_addr_o  output  32  byte address to instruction memory (PC).
REQ-009 SHALL have port: imem_data_i  input  32  little-endian instruction word, combinational from memory.
REQ-010 SHALL have port: ifid_pc_o  output  32  PC of the instruction held in IF/ID.
REQ-011 SHALL have port: ifid_instr_o  output  32  instruction held in IF/ID.
REQ-012 SHALL have port: ifid_valid_o  output  1  IF/ID holds a real instruction.
REQ-013 SHALL have port: fault_o  output  1  misaligned-fetch fault (sticky).

Function
REQ-014 SHALL drive imem_addr_o combinationally from the internal PC register pc_q.
REQ-015 SHALL implement FSM states BOOT, RUN, HALT; BOOT->RUN after exactly one cycle; HALT exits only by reset.
REQ-016 SHALL in BOOT not capture imem_data_i (memory outputs zero during reset); IF/ID stays invalid, pc_q holds.
REQ-017 SHALL in RUN with stall_i=0, redirect_i=0: ifid_instr<=imem_data_i, ifid_pc<=pc_q, ifid_valid<=1, pc_q<=pc_q+4; latency PC-to-IF/ID = 1 cycle.
REQ-018 SHALL in RUN with stall_i=1, redirect_i=0: hold pc_q, ifid_pc, ifid_instr, ifid_valid unchanged.
REQ-019 SHALL on redirect_i=1 (RUN or BOOT): pc_q<=redirect_pc_i, ifid_instr<=NOP_INSTR, ifid_valid<=0, ifid_pc unchanged, state<=RUN.
REQ-020 SHALL give redirect_i priority over stall_i when both asserted.
REQ-021 SHALL compute pc_q+4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000, no flag).
REQ-022 SHALL in HALT hold pc_q, force ifid_valid_o=0, ifid_instr_o=NOP_INSTR, ignore stall_i and redirect_i.

Reset
REQ-023 SHALL on rst=0 at a clock edge set pc_q=RESET_PC, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0, fault_o=0, state=BOOT, overriding all other inputs.
REQ-024 SHALL treat reset mid-operation (RUN, stall, HALT) identically; no pending redirect survives.

Configuration
REQ-025 SHALL with macro IF_MISALIGN_TRAP_EN defined: redirect with redirect_pc_i[1:0]!=0 sets fault_o=1, state<=HALT, pc_q holds.
REQ-026 SHALL without IF_MISALIGN_TRAP_EN: redirect target loaded with bits [1:0] forced to 0; fault_o tied 0; HALT unreachable.

Structure
REQ-027 SHALL place XLEN (32), NOP_INSTR value and the FSM state enum in shared package riscv_pkg.
REQ-028 SHALL implement the IF/ID register as sub-module ifid_reg (inputs: load, flush, hold; outputs pc/instr/valid).

Verification
REQ-029 SHALL test: release reset, RESET_PC=0, memory word0=32'h0050_0093 -> cycle1 BOOT valid=0; cycle2 ifid_instr=32'h0050_0093, ifid_pc=0, valid=1; imem_addr_o=4.
REQ-030 SHALL test: stall_i=1 for 3 cycles at PC=8 -> imem_addr_o stays 8, IF/ID unchanged, resume fetches 8 next.
REQ-031 SHALL test: redirect_i=1, redirect_pc_i=32'h0000_0040 together with stall_i=1 -> next cycle imem_addr_o=0x40, ifid_valid=0, ifid_instr=32'h0000_0013.
REQ-032 SHALL test: pc_q=32'hFFFF_FFFC, no stall -> next imem_addr_o=0, ifid_pc=32'hFFFF_FFFC.
REQ-033 SHALL test: redirect to 32'h0000_0042 -> with IF_MISALIGN_TRAP_EN fault_o=1, valid=0 stuck until rst=0; without it imem_addr_o=32'h0000_0040.
REQ-034 SHALL test: rst=0 asserted during stall at PC=0x20 -> next cycle imem_addr_o=RESET_PC, valid=0, state BOOT.
